// File: rtl/wb_stage_nway.sv
// wb_stage_nway: N-lane MEM/WB pipeline register with in-order exception
// resolution, same-cycle WAW masking, per-lane retire trace and a retired
// instruction counter. Lane 0 holds the oldest instruction of the bundle.
module wb_stage_nway #(
    parameter int unsigned LANES   = 2,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned PC_W    = 32,
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned ECODE_W = 6,
    parameter int unsigned CNT_W   = 32,
    localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [LANES-1:0]          pre_valid_i,
    output logic                      now_allowin_o,
    input  logic                      stall_i,
    input  logic [LANES*PC_W-1:0]     pc_i,
    input  logic [LANES-1:0]          we_i,
    input  logic [LANES*REG_AW-1:0]   waddr_i,
    input  logic [LANES*DATA_W-1:0]   wdata_i,
    input  logic [LANES-1:0]          excep_i,
    input  logic [LANES*ECODE_W-1:0]  ecode_i,
    output logic [LANES-1:0]          rf_we_o,
    output logic [LANES*REG_AW-1:0]   rf_waddr_o,
    output logic [LANES*DATA_W-1:0]   rf_wdata_o,
    output logic                      excep_flush_o,
    output logic [PC_W-1:0]           excep_pc_o,
    output logic [ECODE_W-1:0]        excep_ecode_o,
    output logic [LANE_W-1:0]         excep_lane_o,
    output logic [LANES-1:0]          retire_o,
    output logic [LANES*PC_W-1:0]     retire_pc_o,
    output logic [CNT_W-1:0]          retire_cnt_o
);

    localparam int unsigned INC_W = $clog2(LANES + 1);

    logic [LANES-1:0]          r_valid;
    logic [LANES-1:0]          r_we;
    logic [LANES-1:0]          r_excep;
    logic [LANES*PC_W-1:0]     r_pc;
    logic [LANES*REG_AW-1:0]   r_waddr;
    logic [LANES*DATA_W-1:0]   r_wdata;
    logic [LANES*ECODE_W-1:0]  r_ecode;
    logic [CNT_W-1:0]          r_cnt;

    logic                      w_any_v;
    logic                      w_allowin;
    logic                      w_capture;
    logic                      w_fault;
    logic [LANE_W-1:0]         w_fault_lane;
    logic [PC_W-1:0]           w_fault_pc;
    logic [ECODE_W-1:0]        w_fault_ecode;
    logic [LANES-1:0]          w_killed;
    logic [LANES-1:0]          w_commit;
    logic [LANES-1:0]          w_we_pre;
    logic [LANES-1:0]          w_we;
    logic [INC_W-1:0]          w_pop;

    // A held bundle blocks upstream only while the stage is stalled.
    assign w_any_v   = |r_valid;
    assign w_allowin = !(stall_i && w_any_v);
    assign w_capture = w_allowin && !w_fault;

    // Lane valids: a flush empties the stage, a stall holds it, else capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else if (w_fault) begin
            r_valid <= '0;
        end else if (w_capture) begin
            r_valid <= pre_valid_i;
        end
    end

    // Payload registers load only when a bundle is captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we    <= '0;
            r_excep <= '0;
            r_pc    <= '0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_ecode <= '0;
        end else if (w_capture) begin
            r_we    <= we_i;
            r_excep <= excep_i;
            r_pc    <= pc_i;
            r_waddr <= waddr_i;
            r_wdata <= wdata_i;
            r_ecode <= ecode_i;
        end
    end

    // Oldest faulting lane wins; it and every younger lane are killed.
    always_comb begin
        w_fault       = 1'b0;
        w_fault_lane  = '0;
        w_fault_pc    = '0;
        w_fault_ecode = '0;
        w_killed      = '0;
        for (int k = 0; k < int'(LANES); k++) begin
            if (!stall_i && r_valid[k] && r_excep[k] && !w_fault) begin
                w_fault       = 1'b1;
                w_fault_lane  = LANE_W'(k);
                w_fault_pc    = r_pc[k*PC_W +: PC_W];
                w_fault_ecode = r_ecode[k*ECODE_W +: ECODE_W];
            end
            w_killed[k] = w_fault;
        end
    end

    // Commit enables and raw write enables (r0 writes dropped).
    always_comb begin
        w_commit = '0;
        w_we_pre = '0;
        for (int k = 0; k < int'(LANES); k++) begin
            w_commit[k] = r_valid[k] && !w_killed[k] && !stall_i;
            w_we_pre[k] = w_commit[k] && r_we[k] &&
                          (r_waddr[k*REG_AW +: REG_AW] != '0);
        end
    end

    // WAW: an older writer is masked when any younger lane hits the same register.
    always_comb begin
        w_we = w_we_pre;
        for (int k = 0; k < int'(LANES); k++) begin
            for (int j = k + 1; j < int'(LANES); j++) begin
                if (w_we_pre[j] &&
                    (r_waddr[j*REG_AW +: REG_AW] == r_waddr[k*REG_AW +: REG_AW])) begin
                    w_we[k] = 1'b0;
                end
            end
        end
    end

    // Number of instructions retiring this cycle.
    always_comb begin
        w_pop = '0;
        for (int k = 0; k < int'(LANES); k++) begin
            w_pop = w_pop + INC_W'(w_commit[k]);
        end
    end

    // Retired-instruction counter, wraps freely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(w_pop);
        end
    end

    assign now_allowin_o = w_allowin;
    assign rf_we_o       = w_we;
    assign rf_waddr_o    = r_waddr;
    assign rf_wdata_o    = r_wdata;
    assign excep_flush_o = w_fault;
    assign excep_pc_o    = w_fault_pc;
    assign excep_ecode_o = w_fault_ecode;
    assign excep_lane_o  = w_fault_lane;
    assign retire_o      = w_commit;
    assign retire_pc_o   = r_pc;
    assign retire_cnt_o  = r_cnt;

endmodule
